// File: rtl/ddrc_apb_cfg_master_if.sv
// APB user-port bundle between the DDRC configuration master and the DDRC
// reset controller's user APB port.
//   master modport : drives psel/penable/pwrite/paddr/pwdata, samples prdata/pready
//   slave modport  : the mirror image, for the responding side
interface ddrc_apb_cfg_master_if;
    logic        user_psel;
    logic        user_penable;
    logic        user_pwrite;
    logic [11:0] user_paddr;
    logic [31:0] user_pwdata;
    logic [31:0] user_prdata;
    logic        user_pready;

    modport master (
        output user_psel, user_penable, user_pwrite, user_paddr, user_pwdata,
        input  user_prdata, user_pready
    );

    modport slave (
        input  user_psel, user_penable, user_pwrite, user_paddr, user_pwdata,
        output user_prdata, user_pready
    );
endinterface

// File: rtl/ddrc_apb_cfg_master.sv
// Single-outstanding APB master that turns host config requests into APB
// transfers on the DDRC user port, with an ACCESS-phase timeout.
//
// Ports:
//   pclk, resetn         clock, async active-low reset
//   ddr_init_done        gates acceptance of new host requests
//   req_valid/req_ready  host request handshake; req_write/req_addr/req_wdata payload
//   rsp_valid            one-cycle response strobe; rsp_rdata/rsp_err hold until next response
//   busy                 high whenever a transfer is in flight
//   err_cnt              saturating count of timed-out transfers
//   apb                  APB master side (psel/penable/pwrite/paddr/pwdata, prdata/pready)
//
// state  | meaning
// IDLE   | waiting for a host request (ready while ddr_init_done)
// SETUP  | APB setup phase, one cycle
// ACCESS | APB access phase, waits for pready or timeout
// RESP   | one-cycle response strobe back to host
module ddrc_apb_cfg_master #(
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255,
    parameter int unsigned ERR_CNT_W      = 8
) (
    input  logic                 pclk,
    input  logic                 resetn,
    input  logic                 ddr_init_done,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [11:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_cnt,
    ddrc_apb_cfg_master_if.master apb
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [7:0] WAIT_LAST = TIMEOUT_CYCLES - 8'd1;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       idle_rdy;

    // idle_rdy is registered so req_ready is 0 in reset and in the first
    // cycle after release; ddr_init_done gates it without a cycle of lag.
    assign req_ready = idle_rdy & ddr_init_done;

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            idle_rdy         <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_rdata        <= '0;
            rsp_err          <= 1'b0;
            busy             <= 1'b0;
            err_cnt          <= '0;
            wait_cnt         <= '0;
            apb.user_psel    <= 1'b0;
            apb.user_penable <= 1'b0;
            apb.user_pwrite  <= 1'b0;
            apb.user_paddr   <= '0;
            apb.user_pwdata  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state           <= SETUP;
                        idle_rdy        <= 1'b0;
                        busy            <= 1'b1;
                        wait_cnt        <= '0;
                        apb.user_psel   <= 1'b1;
                        apb.user_pwrite <= req_write;
                        apb.user_paddr  <= req_addr;
                        apb.user_pwdata <= req_wdata;
                    end else begin
                        idle_rdy <= 1'b1;
                    end
                end
                SETUP: begin
                    state            <= ACCESS;
                    apb.user_penable <= 1'b1;
                end
                ACCESS: begin
                    // pready wins over the timeout on the last allowed cycle
                    if (apb.user_pready) begin
                        state            <= RESP;
                        rsp_valid        <= 1'b1;
                        rsp_err          <= 1'b0;
                        rsp_rdata        <= apb.user_pwrite ? 32'h0 : apb.user_prdata;
                        apb.user_psel    <= 1'b0;
                        apb.user_penable <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == WAIT_LAST) begin
                            state            <= RESP;
                            rsp_valid        <= 1'b1;
                            rsp_err          <= 1'b1;
                            rsp_rdata        <= '0;
                            apb.user_psel    <= 1'b0;
                            apb.user_penable <= 1'b0;
                            if (err_cnt != '1) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                        end
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    idle_rdy <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddrc_apb_cfg_master.sv
module tb_ddrc_apb_cfg_master;

    localparam logic [7:0] TO  = 8'd8;
    localparam int         EW  = 2;
    localparam int         EMAX = (1 << EW) - 1;

    logic          pclk = 1'b0;
    logic          resetn;
    logic          ddr_init_done;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [11:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          busy;
    logic [EW-1:0] err_cnt;

    ddrc_apb_cfg_master_if apb ();

    ddrc_apb_cfg_master #(
        .TIMEOUT_CYCLES (TO),
        .ERR_CNT_W      (EW)
    ) u_dut (
        .pclk          (pclk),
        .resetn        (resetn),
        .ddr_init_done (ddr_init_done),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .err_cnt       (err_cnt),
        .apb           (apb.master)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    int exp_errcnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle and ready. delay = number of
    // ACCESS cycles with pready low before pready rises (>= TO means never).
    // rst_at > 0 pulls resetn low at that cycle and abandons the transfer.
    task automatic run_txn(input bit wr, input logic [11:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int delay, input bit drop_init,
                           input int rst_at);
        bit          succ;
        int          acc, lat, n_acc, psel_cnt, pen_cnt, bus_bad, got_at;
        logic [31:0] exp_rd;

        succ   = delay < int'(TO);
        acc    = succ ? delay + 1 : int'(TO);
        lat    = acc + 2;
        exp_rd = (succ && !wr) ? rdata : 32'h0;
        if (!succ) exp_errcnt = (exp_errcnt < EMAX) ? exp_errcnt + 1 : EMAX;

        chk("ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        apb.user_pready = 1'b0;
        n_acc = 0; psel_cnt = 0; pen_cnt = 0; bus_bad = 0; got_at = 0;

        for (int c = 1; c <= 400 && got_at == 0; c++) begin
            @(negedge pclk);
            if (c == 1) begin
                req_valid = 1'b0;
                req_addr  = $urandom;
                req_wdata = $urandom;
                req_write = $urandom;
                if (drop_init) ddr_init_done = 1'b0;
            end
            if (apb.user_psel) begin
                psel_cnt++;
                if (apb.user_paddr !== addr || apb.user_pwdata !== wdata ||
                    apb.user_pwrite !== wr || busy !== 1'b1 || req_ready !== 1'b0)
                    bus_bad++;
            end
            apb.user_pready = 1'b0;
            apb.user_prdata = $urandom;
            if (apb.user_psel && apb.user_penable) begin
                pen_cnt++;
                if (n_acc == delay) begin
                    apb.user_pready = 1'b1;
                    apb.user_prdata = rdata;
                end
                n_acc++;
            end
            if (rsp_valid) got_at = c;
            if (rst_at == c) begin
                resetn = 1'b0;
                apb.user_pready = 1'b0;
                #1;
                chk("rst_apb_outputs",
                    {apb.user_psel, apb.user_penable, apb.user_pwrite, apb.user_paddr, apb.user_pwdata}, 64'h0);
                chk("rst_host_outputs", {req_ready, rsp_valid, rsp_err, busy, rsp_rdata, err_cnt}, 64'h0);
                exp_errcnt = 0;
                return;
            end
        end
        apb.user_pready = 1'b0;

        chk("rsp_seen", got_at != 0, 1'b1);
        chk("latency", got_at, lat);
        chk("rsp_err", rsp_err, !succ);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("err_cnt", err_cnt, exp_errcnt);
        chk("resp_psel_low", {apb.user_psel, apb.user_penable}, 2'b00);
        chk("psel_cycles", psel_cnt, acc + 1);
        chk("penable_cycles", pen_cnt, acc);
        chk("bus_stable", bus_bad, 0);

        @(negedge pclk);
        chk("rsp_one_cycle", rsp_valid, 1'b0);
        chk("idle_not_busy", busy, 1'b0);
        chk("rsp_held", {rsp_err, rsp_rdata}, {!succ, exp_rd});
        chk("ready_after", req_ready, ddr_init_done);
    endtask

    initial begin
        resetn          = 1'b0;
        ddr_init_done   = 1'b1;
        req_valid       = 1'b0;
        req_write       = 1'b0;
        req_addr        = '0;
        req_wdata       = '0;
        apb.user_pready = 1'b0;
        apb.user_prdata = '0;

        repeat (3) @(negedge pclk);
        chk("reset_apb", {apb.user_psel, apb.user_penable, apb.user_pwrite, apb.user_paddr, apb.user_pwdata}, 64'h0);
        chk("reset_host", {req_ready, rsp_valid, rsp_err, busy, rsp_rdata, err_cnt}, 64'h0);

        // hold off acceptance while DDRC init is incomplete
        ddr_init_done = 1'b0;
        @(negedge pclk);
        resetn    = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            chk("init_gate_ready", req_ready, 1'b0);
            chk("init_gate_psel", apb.user_psel, 1'b0);
        end
        req_valid     = 1'b0;
        ddr_init_done = 1'b1;
        @(negedge pclk);

        run_txn(1'b1, 12'h0A4, 32'h0000_1234, 32'h0, 0, 1'b0, 0);
        run_txn(1'b0, 12'h004, 32'h0, 32'hDEAD_BEEF, 5, 1'b0, 0);
        run_txn(1'b0, 12'h010, 32'h0, 32'h5555_AAAA, 100, 1'b0, 0);
        run_txn(1'b0, 12'h014, 32'h0, 32'h1357_9BDF, int'(TO) - 1, 1'b0, 0);
        for (int i = 0; i < 4; i++)
            run_txn(i[0], 12'h100 + 12'(i), $urandom, $urandom, 200, 1'b0, 0);

        // init drops mid-transfer: transfer completes, acceptance then blocked
        run_txn(1'b0, 12'h020, 32'h0, 32'hCAFE_F00D, 2, 1'b1, 0);
        repeat (3) begin
            @(negedge pclk);
            chk("init_low_ready", req_ready, 1'b0);
        end
        ddr_init_done = 1'b1;
        @(negedge pclk);

        for (int i = 0; i < 12; i++)
            run_txn(1'($urandom), 12'($urandom), $urandom, $urandom, int'($urandom_range(0, 10)), 1'b0, 0);

        // reset mid-ACCESS after a read left non-zero response data
        run_txn(1'b0, 12'h030, 32'h0, 32'h8765_4321, 1, 1'b0, 0);
        run_txn(1'b1, 12'h3FC, 32'hA5A5_5A5A, 32'h0, 100, 1'b0, 4);
        repeat (2) begin
            @(negedge pclk);
            chk("rst_no_rsp", rsp_valid, 1'b0);
        end
        resetn = 1'b1;
        repeat (2) @(negedge pclk);
        run_txn(1'b0, 12'h040, 32'h0, 32'h0BAD_CAFE, 3, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddrc_apb_cfg_master.md
DDRC_APB_CFG_MASTER -- requirements
Module: ddrc_apb_cfg_master

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 8'd255, the maximum number of ACCESS cycles to wait for pready before aborting.
REQ-002 SHALL provide parameter ERR_CNT_W, default 8, the width of the saturating error counter.
REQ-003 pclk  in  1  sole clock; all state changes on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 ddr_init_done  in  1  high once DDRC initialisation is complete; gates acceptance of new requests.
REQ-006 req_valid  in  1  host request present.
REQ-007 req_ready  out  1  host request accepted when req_valid=1 and req_ready=1 in the same cycle.
REQ-008 req_write  in  1  1 = APB write, 0 = APB read.
REQ-009 req_addr  in  12  APB address.
REQ-010 req_wdata  in  32  APB write data.
REQ-011 rsp_valid  out  1  single-cycle response strobe.
REQ-012 rsp_rdata  out  32  read data; 0 for writes and for timeouts.
REQ-013 rsp_err  out  1  1 = transaction timed out; qualified by rsp_valid.
REQ-014 user_psel, user_penable, user_pwrite  out  1 each  APB master controls (feed the DDRC reset controller user port).
REQ-015 user_paddr  out  12; user_pwdata  out  32  APB address and write data.
REQ-016 user_prdata  in  32; user_pready  in  1  APB slave response.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 err_cnt  out  ERR_CNT_W  saturating count of timed-out transactions.

Function
REQ-019 FSM states SHALL be IDLE, SETUP, ACCESS and RESP.
REQ-020 IDLE: req_ready = ddr_init_done; on handshake, latch req_write, req_addr and req_wdata, then go to SETUP.
REQ-021 req_ready SHALL be 0 in SETUP, ACCESS and RESP; requests SHALL be accepted one at a time and never queued.
REQ-022 SETUP lasts exactly one cycle: psel=1, penable=0, APB outputs driven from the latched values; then go to ACCESS.
REQ-023 ACCESS: psel=1, penable=1; the wait counter increments every cycle in which pready=0.
REQ-024 ACCESS with pready=1: capture user_prdata if a read (else 0), set rsp_err=0, go to RESP.
REQ-025 ACCESS with pready=0 and wait counter = TIMEOUT_CYCLES-1: abort, set rsp_err=1 and rsp_rdata=0, increment err_cnt (hold at all-ones, no wrap), go to RESP.
REQ-026 pready=1 on the timeout cycle SHALL count as a success, not a timeout.
REQ-027 RESP lasts exactly one cycle: rsp_valid=1, psel=0, penable=0; then go to IDLE.
REQ-028 rsp_rdata and rsp_err SHALL hold their values until the next RESP.
REQ-029 Minimum request-to-response latency SHALL be 3 cycles (SETUP, ACCESS with pready=1, RESP); back-to-back requests SHALL be spaced at least 4 cycles apart.
REQ-030 user_paddr, user_pwdata and user_pwrite SHALL be stable from SETUP through the end of ACCESS.
REQ-031 If ddr_init_done falls during SETUP or ACCESS, the transaction SHALL complete normally; only acceptance of new requests is blocked.
REQ-032 The wait counter SHALL clear on entry to SETUP.

Reset
REQ-033 On resetn=0, asynchronously: state=IDLE; req_ready, rsp_valid, rsp_err, busy, psel, penable and pwrite = 0; paddr, pwdata, rsp_rdata, err_cnt and wait counter = 0.
REQ-034 Reset asserted mid-transaction SHALL abort immediately with no rsp_valid; after release, the block returns to IDLE.
REQ-035 After reset release, req_ready SHALL remain 0 until ddr_init_done=1.

Verification
REQ-036 ddr_init_done=0 with req_valid=1 held for 20 cycles -> req_ready=0 and psel=0 throughout.
REQ-037 Write addr 12'h0A4, data 32'h0000_1234, pready=1 in the first ACCESS cycle -> psel high 2 cycles, penable 1 cycle; rsp_valid on cycle 3 with rsp_err=0 and rsp_rdata=0.
REQ-038 Read addr 12'h004, pready after 5 wait cycles, prdata=32'hDEAD_BEEF -> rsp_rdata=32'hDEAD_BEEF, rsp_err=0, latency 8 cycles.
REQ-039 TIMEOUT_CYCLES=8, pready tied 0 -> abort after 8 ACCESS cycles; rsp_err=1, rsp_rdata=0, err_cnt=1; pready=1 on the 8th ACCESS cycle instead -> success.
REQ-040 ERR_CNT_W=2 with 5 consecutive timeouts -> err_cnt reads 1, 2, 3, 3, 3.
REQ-041 resetn pulsed low during ACCESS -> outputs at reset values, no rsp_valid; the next request completes normally.
